// File: rtl/ctrl_bubble_stage.sv
// ID/EX control-bundle register with hazard bubble insertion and branch flush.
// Define CTRL_STATS_EN to add the saturating BubbleCount statistics counter.
module ctrl_bubble_stage #(
    parameter int                CTRL_W      = 18,
    parameter int                MAX_BUBBLES = 3,
    parameter int                CNT_W       = $clog2(MAX_BUBBLES + 1),
    parameter logic [CTRL_W-1:0] BUBBLE_VAL  = {CTRL_W{1'b0}}
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [CTRL_W-1:0] PreCtrl,
    input  logic              InValid,
    input  logic              HazardReq,
    input  logic [CNT_W-1:0]  HazardLen,
    input  logic              Flush,
    input  logic              Hold,
    output logic [CTRL_W-1:0] Ctrl,
    output logic              CtrlValid,
    output logic              StallUp,
    output logic              PCWrite,
    output logic              Busy
`ifdef CTRL_STATS_EN
    ,
    output logic [15:0]       BubbleCount
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_BUBBLES);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0]  len;
    logic [CTRL_W-1:0] ctrl_nxt;
    logic              valid_nxt;
    logic              stall;
    logic              bubble_load;

    assign len = (HazardLen > MAX_LEN) ? MAX_LEN : HazardLen;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ctrl_nxt    = Ctrl;
        valid_nxt   = CtrlValid;
        stall       = 1'b0;
        bubble_load = 1'b0;
        if (Flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            ctrl_nxt  = BUBBLE_VAL;
            valid_nxt = 1'b0;
        end else if (Hold) begin
            stall = 1'b1;
        end else if (state == IDLE) begin
            if (HazardReq && (len != '0)) begin
                ctrl_nxt    = BUBBLE_VAL;
                valid_nxt   = 1'b0;
                stall       = 1'b1;
                cnt_nxt     = len - ONE;
                state_nxt   = (len != ONE) ? BUBBLE : IDLE;
                bubble_load = 1'b1;
            end else begin
                ctrl_nxt  = PreCtrl;
                valid_nxt = InValid;
            end
        end else begin
            // Countdown: HazardReq is ignored until the FSM is back in IDLE.
            ctrl_nxt    = BUBBLE_VAL;
            valid_nxt   = 1'b0;
            stall       = 1'b1;
            cnt_nxt     = cnt - ONE;
            bubble_load = 1'b1;
            if (cnt == ONE) begin
                state_nxt = IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            Ctrl      <= BUBBLE_VAL;
            CtrlValid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            Ctrl      <= ctrl_nxt;
            CtrlValid <= valid_nxt;
        end
    end

    // Stall is gated by Reset so the PC keeps advancing while the stage is held in reset.
    assign StallUp = stall & ~Reset;
    assign PCWrite = ~StallUp;
    assign Busy    = (state == BUBBLE);

`ifdef CTRL_STATS_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            BubbleCount <= '0;
        end else if (bubble_load && (BubbleCount != 16'hFFFF)) begin
            BubbleCount <= BubbleCount + 16'd1;
        end
    end
`endif

endmodule
